// File: rtl/drum_audio_bridge.sv
// Drum-simulation node stream to audio-core bridge: gain, saturation, FIFO, valid/ready output.
// Optional macro DROP_COUNT_EN adds a saturating drop counter (drop_count) with a clear (clear_drops).
module drum_audio_bridge #(
    parameter int ADDR_W     = 4,
    parameter int GAIN_SHIFT = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [17:0]  node_in,
    input  logic                node_valid,
    output logic signed [15:0]  audio_data,
    output logic                audio_valid,
    input  logic                audio_ready,
    output logic [ADDR_W:0]     fill_level,
    output logic                dropped
`ifdef DROP_COUNT_EN
    ,
    input  logic                clear_drops,
    output logic [15:0]         drop_count
`endif
);

    localparam int DATA_W = 18;
    localparam int PCM_W  = 16;
    localparam int WIDE_W = 26;
    localparam int DEPTH  = 2 ** ADDR_W;

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    localparam logic signed [WIDE_W-1:0] PCM_MAX = 26'sd32767;
    localparam logic signed [WIDE_W-1:0] PCM_MIN = -26'sd32768;

    typedef enum logic {S_EMPTY, S_PRESENT} state_t;

    function automatic logic signed [WIDE_W-1:0] scale_gain(input logic signed [DATA_W-1:0] s);
        logic signed [WIDE_W-1:0] w;
        w = {{(WIDE_W - DATA_W){s[DATA_W-1]}}, s};
        w = w <<< GAIN_SHIFT;
        return w >>> 2;
    endfunction

    function automatic logic signed [PCM_W-1:0] sat_pcm(input logic signed [WIDE_W-1:0] x);
        if (x > PCM_MAX) return 16'sh7FFF;
        if (x < PCM_MIN) return -16'sh8000;
        return x[PCM_W-1:0];
    endfunction

    logic                     admit;
    logic                     vld_p1_q, vld_p1_d;
    logic signed [PCM_W-1:0]  data_p1_q, data_p1_d;
    logic signed [PCM_W-1:0]  mem_q [DEPTH];
    logic signed [PCM_W-1:0]  mem_d [DEPTH];
    logic [ADDR_W-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_W:0]          cnt_q, cnt_d;
    logic [ADDR_W:0]          fill_q, fill_d;
    state_t                   state_q, state_d;
    logic signed [PCM_W-1:0]  audio_data_q, audio_data_d;
    logic                     dropped_q, dropped_d;
    logic                     rd_en;
    logic                     handshake;

    // Stage 1: admission and conversion; space freed by a same-cycle read is not counted.
    always_comb begin
        admit     = node_valid && (fill_q < DEPTH_CNT);
        dropped_d = node_valid && !admit;
        vld_p1_d  = admit;
        data_p1_d = data_p1_q;
        if (admit) begin
            data_p1_d = sat_pcm(scale_gain(node_in));
        end
    end

    // Output register FSM: reload on handshake so a non-empty FIFO streams without bubbles.
    always_comb begin
        state_d      = state_q;
        audio_data_d = audio_data_q;
        rd_en        = 1'b0;
        unique case (state_q)
            S_EMPTY: begin
                if (cnt_q != '0) begin
                    rd_en   = 1'b1;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (audio_ready) begin
                    if (cnt_q != '0) rd_en = 1'b1;
                    else             state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (rd_en) begin
            audio_data_d = mem_q[rptr_q];
        end
    end

    assign handshake = (state_q == S_PRESENT) && audio_ready;

    // Stage 2: conversion register drains into FIFO memory.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (vld_p1_q) begin
            mem_d[wptr_q] = data_p1_q;
            wptr_d        = wptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        unique case ({vld_p1_q, rd_en})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        unique case ({admit, handshake})
            2'b10:   fill_d = fill_q + CNT_ONE;
            2'b01:   fill_d = fill_q - CNT_ONE;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1_q     <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            fill_q       <= '0;
            state_q      <= S_EMPTY;
            audio_data_q <= '0;
            dropped_q    <= 1'b0;
        end else begin
            vld_p1_q     <= vld_p1_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            fill_q       <= fill_d;
            state_q      <= state_d;
            audio_data_q <= audio_data_d;
            dropped_q    <= dropped_d;
        end
    end

    always_ff @(posedge clk) begin
        data_p1_q <= data_p1_d;
        mem_q     <= mem_d;
    end

    assign audio_data  = audio_data_q;
    assign audio_valid = (state_q == S_PRESENT);
    assign fill_level  = fill_q;
    assign dropped     = dropped_q;

`ifdef DROP_COUNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear_drops) begin
            drop_cnt_d = '0;
        end else if (dropped_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule
